i2s_ser_tx: RTL



---
 rtl/i2s_ser_tx_if.sv | 12 +
 rtl/i2s_ser_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/i2s_ser_tx_if.sv
// Sample-pair handshake between a producer and the I2S transmitter.
interface i2s_ser_tx_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] lft_in;
  logic [DATA_W-1:0] rght_in;
  logic              vld;
  logic              rdy;

  modport master (output lft_in, output rght_in, output vld, input rdy);
  modport slave  (input lft_in, input rght_in, input vld, output rdy);
endinterface

// File: rtl/i2s_ser_tx.sv
// I2S master transmitter: one-deep holding register feeding a left/right frame
// serializer that generates sclk, ws (leading the MSB by one bit) and data.
module i2s_ser_tx #(
  parameter int SCLK_DIV = 16,
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  i2s_ser_tx_if.slave smp,
  output logic        I2S_sclk,
  output logic        I2S_ws,
  output logic        I2S_data,
  output logic        frm_strt,
  output logic        underflow
);

  localparam int FRM_W = 2 * SLOT_W;
  localparam int K_W   = $clog2(FRM_W);
  localparam int DIV_W = $clog2(SCLK_DIV);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [K_W-1:0]    k_q;
  logic [DATA_W-1:0] hold_l_q, hold_r_q, frm_l_q, frm_r_q;
  logic              hold_full_q, rdy_q;
  logic              sclk_q, ws_q, data_q, frm_strt_q, ufl_q;

  logic [K_W-1:0]    k_d;
  logic [DATA_W-1:0] nxt_l_d, nxt_r_d;
  logic              tick_s, fall_s, bnd_s, acc_s;

  function automatic logic ws_at(input logic [K_W-1:0] k);
    int ki;
    ki = int'(k);
    return (ki >= SLOT_W - 1) && (ki <= 2 * SLOT_W - 2);
  endfunction

  // Bit k of the frame: left MSB-first, then right MSB-first, zero padding.
  function automatic logic data_at(input logic [K_W-1:0] k,
                                   input logic [DATA_W-1:0] l,
                                   input logic [DATA_W-1:0] r);
    logic [DATA_W-1:0] sh;
    int ki;
    ki = int'(k);
    if (ki < DATA_W) begin
      sh = l << k;
    end else if ((ki >= SLOT_W) && (ki < SLOT_W + DATA_W)) begin
      sh = r << (k - K_W'(SLOT_W));
    end else begin
      sh = '0;
    end
    return sh[DATA_W-1];
  endfunction

  // Divider terminal count, sclk fall, frame boundary and the next frame source.
  always_comb begin
    tick_s  = (div_q == DIV_W'(SCLK_DIV - 1));
    fall_s  = tick_s && sclk_q && (state_q == RUN);
    bnd_s   = fall_s && (k_q == K_W'(FRM_W - 1));
    acc_s   = smp.vld && rdy_q;
    k_d     = (k_q == K_W'(FRM_W - 1)) ? '0 : k_q + K_W'(1);
    nxt_l_d = (bnd_s && hold_full_q) ? hold_l_q : frm_l_q;
    nxt_r_d = (bnd_s && hold_full_q) ? hold_r_q : frm_r_q;
  end

  // Handshake, frame sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      k_q         <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      frm_l_q     <= '0;
      frm_r_q     <= '0;
      hold_full_q <= 1'b0;
      rdy_q       <= 1'b1;
      sclk_q      <= 1'b0;
      ws_q        <= 1'b0;
      data_q      <= 1'b0;
      frm_strt_q  <= 1'b0;
      ufl_q       <= 1'b0;
    end else begin
      frm_strt_q <= 1'b0;
      ufl_q      <= 1'b0;

      // rdy re-opens one clk after the holding register was drained.
      if (acc_s) begin
        hold_l_q    <= smp.lft_in;
        hold_r_q    <= smp.rght_in;
        hold_full_q <= 1'b1;
        rdy_q       <= 1'b0;
      end else if (!rdy_q && !hold_full_q) begin
        rdy_q <= 1'b1;
      end else begin
        rdy_q <= rdy_q;
      end

      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            state_q     <= RUN;
            div_q       <= '0;
            k_q         <= '0;
            sclk_q      <= 1'b0;
            frm_l_q     <= hold_l_q;
            frm_r_q     <= hold_r_q;
            hold_full_q <= 1'b0;
            frm_strt_q  <= 1'b1;
            ws_q        <= ws_at(K_W'(0));
            data_q      <= data_at(K_W'(0), hold_l_q, hold_r_q);
          end else begin
            sclk_q <= 1'b0;
            ws_q   <= 1'b0;
            data_q <= 1'b0;
          end
        end
        RUN: begin
          div_q <= tick_s ? '0 : div_q + DIV_W'(1);
          if (tick_s) begin
            sclk_q <= ~sclk_q;
          end else begin
            sclk_q <= sclk_q;
          end
          if (fall_s) begin
            k_q    <= k_d;
            ws_q   <= ws_at(k_d);
            data_q <= data_at(k_d, nxt_l_d, nxt_r_d);
          end else begin
            k_q <= k_q;
          end
          // Empty holding register at the boundary: replay the last frame.
          if (bnd_s) begin
            frm_l_q    <= nxt_l_d;
            frm_r_q    <= nxt_r_d;
            frm_strt_q <= 1'b1;
            if (hold_full_q) begin
              hold_full_q <= 1'b0;
            end else begin
              ufl_q <= 1'b1;
            end
          end else begin
            frm_l_q <= frm_l_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign smp.rdy   = rdy_q;
  assign I2S_sclk  = sclk_q;
  assign I2S_ws    = ws_q;
  assign I2S_data  = data_q;
  assign frm_strt  = frm_strt_q;
  assign underflow = ufl_q;

endmodule
